// File: rtl/pmm_pkg.sv
// Shared types and constants for the pattern-match core.
// Optional build macro: PMM_WILDCARD_EN (pattern byte '.' matches any text byte).
package pmm_pkg;

    localparam int         MAX_PAT       = 8;
    localparam logic [7:0] WILDCARD_BYTE = 8'h2E;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_LOAD  = 2'b01,
        OP_TEXT  = 2'b10,
        OP_CLEAR = 2'b11
    } opcode_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_e;

    // Decoded request word.
    typedef struct packed {
        opcode_e    op;
        logic [3:0] n;
    } req_t;

    // Byte count 0 or anything above max_n means a full word.
    function automatic logic [3:0] clamp_count(input logic [3:0] c, input int max_n);
        return (c == 4'd0 || int'(c) > max_n) ? 4'(max_n) : c;
    endfunction

endpackage

// File: rtl/pmm_byte_cmp.sv
// L-masked compare of the newest L history bytes against pattern bytes 0..L-1.
// History lane NUM_LANES-1 is the newest byte; lane k lines up with pattern
// byte k+L-NUM_LANES when that index is non-negative.
// Optional build macro: PMM_WILDCARD_EN.
module pmm_byte_cmp #(
    parameter int NUM_LANES = 8
) (
    input  logic [NUM_LANES-1:0][7:0] hist,
    input  logic [NUM_LANES-1:0][7:0] pat,
    input  logic [3:0]                len,
    output logic                      match
);
    import pmm_pkg::*;

    localparam int IW = $clog2(NUM_LANES);

    logic [NUM_LANES-1:0] lane_hit;

    function automatic logic byte_eq(input logic [7:0] h, input logic [7:0] p);
`ifdef PMM_WILDCARD_EN
        return (p == WILDCARD_BYTE) || (h == p);
`else
        return h == p;
`endif
    endfunction

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic [4:0]    sum;
        logic [4:0]    off;
        logic [IW-1:0] pidx;
        assign sum      = 5'(k) + {1'b0, len};
        assign off      = sum - 5'(NUM_LANES);
        assign pidx     = off[IW-1:0];
        // Lanes older than the pattern window always pass.
        assign lane_hit[k] = (sum < 5'(NUM_LANES)) || byte_eq(hist[k], pat[pidx]);
    end

    assign match = (len != 4'd0) && (&lane_hit);

endmodule

// File: rtl/pmm_core.sv
// Streaming byte pattern matcher: LOAD a pattern, feed TEXT words one byte
// per cycle into an 8-byte history, raise a sticky flag on a match.
// Optional build macro: PMM_WILDCARD_EN.
module pmm_core #(
    parameter int MAX_PAT = pmm_pkg::MAX_PAT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [MAX_PAT*8-1:0] INP_DATA,
    input  logic [15:0]          INP_CONTROL,
    input  logic                 DATA_VALID,
    output logic                 READY_STATUS,
    output logic                 ACCEPTED_STATUS
);
    import pmm_pkg::*;

    localparam int IW = $clog2(MAX_PAT);

    state_e                    state_q, state_nxt;
    logic                      ready_q;
    logic                      acc_q;
    logic [MAX_PAT-1:0][7:0]   pat_q, pat_nxt;
    logic [3:0]                len_q;
    logic [MAX_PAT-1:0][7:0]   hist_q, hist_nxt;
    logic [MAX_PAT-1:0][7:0]   text_q;
    logic [3:0]                cnt_q;
    logic [3:0]                idx_q;
    logic [MAX_PAT-1:0][7:0]   data_w;
    req_t                      req;
    logic                      xfer;
    logic                      last_byte;
    logic                      hit;
    logic                      unused_ctrl;

    assign data_w      = INP_DATA;
    assign req.op      = opcode_e'(INP_CONTROL[15:14]);
    assign req.n       = clamp_count(INP_CONTROL[3:0], MAX_PAT);
    assign unused_ctrl = ^INP_CONTROL[13:4];
    assign xfer        = DATA_VALID && ready_q;
    assign last_byte   = (idx_q == cnt_q - 4'd1);

    // History as it will look once the current scan byte shifts in.
    assign hist_nxt = {text_q[idx_q[IW-1:0]], hist_q[MAX_PAT-1:1]};

    pmm_byte_cmp #(.NUM_LANES(MAX_PAT)) u_cmp (
        .hist  (hist_nxt),
        .pat   (pat_q),
        .len   (len_q),
        .match (hit)
    );

    // Next-state decode and pattern masking for LOAD.
    always_comb begin
        state_nxt = state_q;
        pat_nxt   = '0;
        for (int j = 0; j < MAX_PAT; j++)
            pat_nxt[j] = (j < int'(req.n)) ? data_w[j] : 8'h00;
        case (state_q)
            S_IDLE:  if (xfer && req.op == OP_TEXT) state_nxt = S_SCAN;
            S_SCAN:  if (last_byte) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM state and registered ready flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_nxt;
            ready_q <= (state_nxt == S_IDLE);
        end
    end

    // Pattern, history, scan counters and the sticky match flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pat_q  <= '0;
            len_q  <= '0;
            hist_q <= '0;
            text_q <= '0;
            cnt_q  <= 4'd1;
            idx_q  <= '0;
            acc_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (xfer) begin
                        case (req.op)
                            OP_LOAD: begin
                                pat_q  <= pat_nxt;
                                len_q  <= req.n;
                                hist_q <= '0;
                                acc_q  <= 1'b0;
                            end
                            OP_CLEAR: begin
                                hist_q <= '0;
                                acc_q  <= 1'b0;
                            end
                            OP_TEXT: begin
                                text_q <= data_w;
                                cnt_q  <= req.n;
                                idx_q  <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_SCAN: begin
                    hist_q <= hist_nxt;
                    idx_q  <= idx_q + 4'd1;
                    if (hit) acc_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign READY_STATUS    = ready_q;
    assign ACCEPTED_STATUS = acc_q;

endmodule

// File: tb/tb_pmm_core.sv
// Scenario bench for pmm_core: expected ready/flag samples are queued as each
// word is driven and compared against per-cycle DUT samples.
module tb_pmm_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] INP_DATA;
    logic [15:0] INP_CONTROL;
    logic        DATA_VALID;
    logic        READY_STATUS;
    logic        ACCEPTED_STATUS;

    pmm_core dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .INP_DATA        (INP_DATA),
        .INP_CONTROL     (INP_CONTROL),
        .DATA_VALID      (DATA_VALID),
        .READY_STATUS    (READY_STATUS),
        .ACCEPTED_STATUS (ACCEPTED_STATUS)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic ready;
        logic acc;
    } smp_t;

    smp_t exp_q[$];
    smp_t obs_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference state: pattern bytes, 8-byte history (oldest first), flag.
    byte unsigned m_pat[$];
    byte unsigned m_hist[$];
    bit           m_acc;

    function automatic int clampn(input int c);
        return (c == 0 || c > 8) ? 8 : c;
    endfunction

    function automatic void m_clear_hist();
        m_hist.delete();
        for (int i = 0; i < 8; i++) m_hist.push_back(8'h00);
    endfunction

    function automatic bit m_match();
        int L = m_pat.size();
        if (L == 0) return 1'b0;
        for (int j = 0; j < L; j++) begin
`ifdef PMM_WILDCARD_EN
            if (m_pat[j] == 8'h2E) continue;
`endif
            if (m_hist[8 - L + j] != m_pat[j]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void push_exp(input logic r, input logic a);
        smp_t s;
        s.ready = r;
        s.acc   = a;
        exp_q.push_back(s);
    endfunction

    function automatic void m_reset();
        m_pat.delete();
        m_clear_hist();
        m_acc = 1'b0;
    endfunction

    // Drive one word at a negedge, queue the expected samples, then step the
    // clock recording one DUT sample per expected entry.
    task automatic xfer(input logic [1:0] op, input int cnt, input logic [63:0] data, input bit hold);
        int   n = clampn(cnt);
        int   m = 1;
        smp_t o;
        INP_DATA    = data;
        INP_CONTROL = {op, 10'h0, 4'(cnt)};
        DATA_VALID  = 1'b1;
        case (op)
            2'b01: begin
                m_pat.delete();
                for (int j = 0; j < n; j++) m_pat.push_back(data[8*j +: 8]);
                m_clear_hist();
                m_acc = 1'b0;
                push_exp(1'b1, 1'b0);
            end
            2'b11: begin
                m_clear_hist();
                m_acc = 1'b0;
                push_exp(1'b1, 1'b0);
            end
            2'b10: begin
                push_exp(1'b0, m_acc);
                for (int i = 0; i < n; i++) begin
                    void'(m_hist.pop_front());
                    m_hist.push_back(data[8*i +: 8]);
                    if (m_match()) m_acc = 1'b1;
                    push_exp(i == n - 1, m_acc);
                end
                m = n + 1;
            end
            default: push_exp(1'b1, m_acc);
        endcase
        for (int c = 0; c < m; c++) begin
            @(posedge clk);
            @(negedge clk);
            o.ready = READY_STATUS;
            o.acc   = ACCEPTED_STATUS;
            obs_q.push_back(o);
            if (!hold || c == m - 1) DATA_VALID = 1'b0;
        end
    endtask

    task automatic test_reset();
        smp_t e, o;
        rst_n       = 1'b0;
        DATA_VALID  = 1'b1;
        INP_DATA    = 64'h4241;
        INP_CONTROL = {2'b01, 10'h0, 4'd2};
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (READY_STATUS !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", READY_STATUS); end
        checks++;
        if (ACCEPTED_STATUS !== 1'b0) begin failures++; $display("FAIL reset_acc got=%b want=0", ACCEPTED_STATUS); end
        rst_n      = 1'b1;
        DATA_VALID = 1'b0;
        m_reset();
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (READY_STATUS !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b want=1", READY_STATUS); end
        // The LOAD held during reset must not have taken effect.
        xfer(2'b10, 2, 64'h4241, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.ready !== e.ready || o.acc !== e.acc) begin
                failures++;
                $display("FAIL reset_text got ready=%b acc=%b want ready=%b acc=%b", o.ready, o.acc, e.ready, e.acc);
            end
        end
        checks++;
        if (ACCEPTED_STATUS !== 1'b0) begin failures++; $display("FAIL reset_priority acc got=%b want=0", ACCEPTED_STATUS); end
    endtask

    task automatic test_basic();
        smp_t e, o;
        int   lows = 0;
        xfer(2'b01, 2, 64'h4241, 1'b0);
        xfer(2'b10, 4, 64'h0000_0000_4241_7878, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            if (o.ready === 1'b0) lows++;
            checks++;
            if (o.ready !== e.ready || o.acc !== e.acc) begin
                failures++;
                $display("FAIL basic got ready=%b acc=%b want ready=%b acc=%b", o.ready, o.acc, e.ready, e.acc);
            end
        end
        checks++;
        if (lows != 4) begin failures++; $display("FAIL basic_ready_low got=%0d want=4", lows); end
        checks++;
        if (ACCEPTED_STATUS !== 1'b1) begin failures++; $display("FAIL basic_acc got=%b want=1", ACCEPTED_STATUS); end
    endtask

    task automatic test_span();
        smp_t e, o;
        xfer(2'b01, 2, 64'h4241, 1'b0);
        xfer(2'b10, 4, 64'h4178_7878, 1'b0);
        checks++;
        if (ACCEPTED_STATUS !== 1'b0) begin failures++; $display("FAIL span_first_word acc got=%b want=0", ACCEPTED_STATUS); end
        xfer(2'b10, 3, 64'h78_7842, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.ready !== e.ready || o.acc !== e.acc) begin
                failures++;
                $display("FAIL span got ready=%b acc=%b want ready=%b acc=%b", o.ready, o.acc, e.ready, e.acc);
            end
        end
        checks++;
        if (ACCEPTED_STATUS !== 1'b1) begin failures++; $display("FAIL span_acc got=%b want=1", ACCEPTED_STATUS); end
    endtask

    task automatic test_clear();
        smp_t e, o;
        xfer(2'b11, 0, 64'h0, 1'b0);
        checks++;
        if (ACCEPTED_STATUS !== 1'b0) begin failures++; $display("FAIL clear_acc got=%b want=0", ACCEPTED_STATUS); end
        xfer(2'b00, 0, 64'h4241, 1'b0);
        xfer(2'b10, 2, 64'h4241, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.ready !== e.ready || o.acc !== e.acc) begin
                failures++;
                $display("FAIL clear got ready=%b acc=%b want ready=%b acc=%b", o.ready, o.acc, e.ready, e.acc);
            end
        end
        checks++;
        if (ACCEPTED_STATUS !== 1'b1) begin failures++; $display("FAIL clear_rematch got=%b want=1", ACCEPTED_STATUS); end
    endtask

    task automatic test_count_clamp();
        smp_t e, o;
        int   lows;
        xfer(2'b01, 1, 64'h51, 1'b0);
        for (int k = 0; k < 2; k++) begin
            lows = 0;
            if (k == 0) xfer(2'b10, 0, 64'h0102_0304_0506_0708, 1'b1);
            else        xfer(2'b10, 12, 64'h5100_0000_0000_0000, 1'b1);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                if (o.ready === 1'b0) lows++;
                checks++;
                if (o.ready !== e.ready || o.acc !== e.acc) begin
                    failures++;
                    $display("FAIL clamp%0d got ready=%b acc=%b want ready=%b acc=%b", k, o.ready, o.acc, e.ready, e.acc);
                end
            end
            checks++;
            if (lows != 8) begin failures++; $display("FAIL clamp%0d_ready_low got=%0d want=8", k, lows); end
        end
        checks++;
        if (ACCEPTED_STATUS !== 1'b1) begin failures++; $display("FAIL clamp_acc got=%b want=1", ACCEPTED_STATUS); end
    endtask

    task automatic test_back_to_back();
        smp_t e, o;
        xfer(2'b01, 0, 64'h4847_4645_4443_4241, 1'b0);
        xfer(2'b10, 3, 64'h43_4241, 1'b0);
        xfer(2'b10, 5, 64'h48_4746_4544, 1'b0);
        xfer(2'b00, 3, 64'h0, 1'b0);
        xfer(2'b10, 1, 64'h41, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.ready !== e.ready || o.acc !== e.acc) begin
                failures++;
                $display("FAIL b2b got ready=%b acc=%b want ready=%b acc=%b", o.ready, o.acc, e.ready, e.acc);
            end
        end
        checks++;
        if (ACCEPTED_STATUS !== 1'b1) begin failures++; $display("FAIL b2b_full_pattern got=%b want=1", ACCEPTED_STATUS); end
    endtask

    task automatic test_wildcard();
        smp_t e, o;
        logic want;
`ifdef PMM_WILDCARD_EN
        want = 1'b1;
`else
        want = 1'b0;
`endif
        xfer(2'b01, 3, 64'h43_2E41, 1'b0);
        xfer(2'b10, 3, 64'h43_5841, 1'b0);
        checks++;
        if (ACCEPTED_STATUS !== want) begin failures++; $display("FAIL wildcard_axc got=%b want=%b", ACCEPTED_STATUS, want); end
        xfer(2'b11, 0, 64'h0, 1'b0);
        xfer(2'b10, 3, 64'h43_2E41, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.ready !== e.ready || o.acc !== e.acc) begin
                failures++;
                $display("FAIL wildcard got ready=%b acc=%b want ready=%b acc=%b", o.ready, o.acc, e.ready, e.acc);
            end
        end
        checks++;
        if (ACCEPTED_STATUS !== 1'b1) begin failures++; $display("FAIL wildcard_literal_dot got=%b want=1", ACCEPTED_STATUS); end
    endtask

    task automatic test_midscan_reset();
        smp_t e, o;
        xfer(2'b01, 2, 64'h4241, 1'b0);
        xfer(2'b10, 2, 64'h4241, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.ready !== e.ready || o.acc !== e.acc) begin
                failures++;
                $display("FAIL midscan_setup got ready=%b acc=%b want ready=%b acc=%b", o.ready, o.acc, e.ready, e.acc);
            end
        end
        INP_DATA    = 64'h4241_4241_4241_4241;
        INP_CONTROL = {2'b10, 10'h0, 4'd8};
        DATA_VALID  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        DATA_VALID = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (READY_STATUS !== 1'b1) begin failures++; $display("FAIL midscan_reset_ready got=%b want=1", READY_STATUS); end
        checks++;
        if (ACCEPTED_STATUS !== 1'b0) begin failures++; $display("FAIL midscan_reset_acc got=%b want=0", ACCEPTED_STATUS); end
        rst_n = 1'b1;
        m_reset();
        xfer(2'b10, 2, 64'h4241, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.ready !== e.ready || o.acc !== e.acc) begin
                failures++;
                $display("FAIL midscan_after got ready=%b acc=%b want ready=%b acc=%b", o.ready, o.acc, e.ready, e.acc);
            end
        end
        checks++;
        if (ACCEPTED_STATUS !== 1'b0) begin failures++; $display("FAIL midscan_no_pattern got=%b want=0", ACCEPTED_STATUS); end
    endtask

    initial begin
        rst_n       = 1'b0;
        DATA_VALID  = 1'b0;
        INP_DATA    = '0;
        INP_CONTROL = '0;
        m_reset();
        test_reset();
        test_basic();
        test_span();
        test_clear();
        test_count_clamp();
        test_back_to_back();
        test_wildcard();
        test_midscan_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pmm_core.md
PMM_CORE -- requirements
Module: pmm_core

Interface
REQ-001 Parameter MAX_PAT, default 8: maximum pattern length in bytes, one 64-bit word.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset; synchronous and active-low.
REQ-004 INP_DATA  input  64  text or pattern bytes; byte k = bits [8k+7:8k], byte 0 first in time.
REQ-005 INP_CONTROL  input  16  [15:14] opcode (00 NOP, 01 LOAD, 10 TEXT, 11 CLEAR); [3:0] byte count; [13:4] ignored.
REQ-006 DATA_VALID  input  1  requester presents INP_DATA/INP_CONTROL this cycle.
REQ-007 READY_STATUS  output  1  registered; module can accept a word this cycle.
REQ-008 ACCEPTED_STATUS  output  1  registered; sticky flag: pattern found in text stream.

Function
REQ-009 A word SHALL transfer only on a rising edge where DATA_VALID=1 and READY_STATUS=1; otherwise inputs are ignored.
REQ-010 Byte count N SHALL be the [3:0] value clamped to 1..8; a value of 0 or any value above 8 gives N=8.
REQ-011 FSM states SHALL be IDLE and SCAN; IDLE drives READY_STATUS=1, SCAN drives READY_STATUS=0.
REQ-012 NOP transfer SHALL have no effect and the FSM SHALL stay in IDLE.
REQ-013 LOAD transfer SHALL store bytes 0..N-1 as the pattern and set pattern length L=N in one cycle.
REQ-014 LOAD SHALL also clear the byte history and ACCEPTED_STATUS, and the FSM SHALL stay in IDLE.
REQ-015 CLEAR transfer SHALL clear the history and ACCEPTED_STATUS, keep the pattern, and stay in IDLE.
REQ-016 TEXT transfer at edge T SHALL capture the word and N, and enter SCAN.
REQ-017 In SCAN, text byte i SHALL be consumed at edge T+1+i, for i = 0..N-1.
REQ-018 The FSM SHALL return to IDLE at edge T+N; READY_STATUS is therefore low for exactly N cycles.
REQ-019 Each consumed byte SHALL shift into an 8-byte history, newest byte last.
REQ-020 ACCEPTED_STATUS SHALL set at the edge where the newest L history bytes, oldest first, equal pattern bytes 0..L-1.
REQ-021 Matches spanning word boundaries SHALL be detected.
REQ-022 L=0 (no pattern loaded) SHALL never match.
REQ-023 ACCEPTED_STATUS SHALL stay set until a CLEAR, a LOAD or reset.
REQ-024 Bytes remaining in a word after a match SHALL still be consumed.

Reset
REQ-025 With rst_n=0 at an edge: FSM=IDLE, READY_STATUS=1, ACCEPTED_STATUS=0.
REQ-026 With rst_n=0 at an edge: history, pattern and L=0 cleared; any in-progress scan is abandoned.
REQ-027 Reset SHALL have priority over any transfer in the same cycle.
REQ-028 READY_STATUS SHALL read 1 in the first cycle after reset is released.

Configuration
REQ-029 With PMM_WILDCARD_EN defined, pattern byte 0x2E ('.') SHALL match any text byte.
REQ-030 Without PMM_WILDCARD_EN, 0x2E SHALL match only 0x2E.

Structure
REQ-031 Shared package pmm_pkg SHALL hold the opcode enum, the FSM state enum, MAX_PAT and the wildcard byte constant.
REQ-032 Sub-module pmm_byte_cmp SHALL do the combinational L-masked compare of history against pattern, with optional wildcard.

Verification
REQ-033 Scenario: LOAD 0x4241 ("AB", count 2); TEXT 0x0000_0000_4241_7878 ("xxAB", count 4) -> READY_STATUS low 4 cycles; ACCEPTED_STATUS rises at the 4th consumed byte.
REQ-034 Scenario: pattern "AB"; TEXT "xxxA" (count 4), then TEXT "Bxx" (count 3) -> ACCEPTED_STATUS sets at the first byte of the second word.
REQ-035 Scenario: after a match, CLEAR -> ACCEPTED_STATUS=0 next cycle; TEXT "AB" -> set again, since the pattern is retained.
REQ-036 Scenario: count field 0 and 12 -> READY_STATUS low 8 cycles each; DATA_VALID held high while READY_STATUS=0 -> no extra transfer.
REQ-037 Scenario: rst_n low mid-SCAN -> READY_STATUS=1 and ACCEPTED_STATUS=0 next cycle; TEXT "AB" afterwards -> no match, since L=0.
REQ-038 Scenario: pattern "A.C" (0x43_2E_41); TEXT "AXC" -> match only with PMM_WILDCARD_EN defined.
